// File: rtl/seq_match_ctrl.sv
// rtl/seq_match_ctrl.sv - serial 1010 match counter: capture a word, shift it MSB first, report the count
// Detector state survives across words when in_chain is set, so patterns may straddle word boundaries.
module seq_match_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             match,
    output logic             busy
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } det_t;

    state_t           state;
    state_t           state_nxt;
    det_t             det;
    det_t             det_nxt;
    logic [WIDTH-1:0] word;
    logic [IDX_W-1:0] bit_idx;
    logic             capture;
    logic             w;

    assign capture = (state == IDLE) && in_valid;
    assign w       = word[WIDTH-1];

    // Overlapping Moore detector for 1010; S4 means the last four bits were 1010.
    always_comb begin
        det_nxt = S0;
        case (det)
            S0:      det_nxt = w ? S1 : S0;
            S1:      det_nxt = w ? S1 : S2;
            S2:      det_nxt = w ? S3 : S0;
            S3:      det_nxt = w ? S1 : S4;
            S4:      det_nxt = w ? S3 : S0;
            default: det_nxt = S0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SHIFT;
            SHIFT:   if (bit_idx == '0) state_nxt = REPORT;
            REPORT:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            det       <= S0;
            word      <= '0;
            bit_idx   <= '0;
            out_count <= '0;
        end else if (capture) begin
            word      <= in_data;
            bit_idx   <= IDX_W'(WIDTH - 1);
            out_count <= '0;
            if (!in_chain) det <= S0;
        end else if (state == SHIFT) begin
            word    <= {word[WIDTH-2:0], 1'b0};
            det     <= det_nxt;
            bit_idx <= bit_idx - 1'b1;
            // Saturate rather than wrap so a narrow counter still reports "many".
            if (det_nxt == S4 && out_count != CNT_MAX) out_count <= out_count + 1'b1;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == REPORT);
    assign busy      = (state != IDLE);
    assign match     = (det == S4);

endmodule

// File: tb/tb_seq_match_ctrl.sv
// tb/tb_seq_match_ctrl.sv - self-checking bench for seq_match_ctrl (table, corner sequences, random)
module tb_seq_match_ctrl;

    localparam int W = 8;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_chain;
    logic       out_ready;
    logic       in_ready, out_valid, match, busy;
    logic [3:0] out_count;
    logic       in_ready_s, out_valid_s, match_s, busy_s;
    logic [0:0] out_count_s;

    int errors = 0;
    int checks = 0;

    // Reference model: bit history since the last detector restart.
    logic [3:0] m_hist;
    int         m_n;
    int         m_cnt;

    seq_match_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_chain(in_chain), .out_valid(out_valid),
        .out_ready(out_ready), .out_count(out_count), .match(match), .busy(busy)
    );

    seq_match_ctrl #(.WIDTH(8), .CNT_W(1)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_chain(in_chain), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_count(out_count_s), .match(match_s), .busy(busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_match();
        return (m_n >= 4) && (m_hist == 4'b1010);
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // exp < 0 means "use the model count"; otherwise exp is the known answer.
    task automatic send(input logic [7:0] d, input logic c, input int hold,
                        input bit noise, input int exp);
        int budget;
        int want;
        logic [3:0] held;
        budget = 0;
        @(negedge clk);
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("ready_wait", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = d;
        in_chain  = c;
        out_ready = 1'b0;
        if (!c) m_n = 0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        for (int k = 1; k <= W; k++) begin
            if (noise) begin
                in_valid  = 1'($urandom);
                in_data   = 8'($urandom);
                in_chain  = 1'($urandom);
                out_ready = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            m_hist = {m_hist[2:0], d[W-k]};
            if (m_n < 4) m_n++;
            if (m_match()) m_cnt++;
            check("shift_match", match, int'(m_match()));
            check("shift_valid", out_valid, int'(k == W));
            check("shift_busy", busy, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        want = (exp < 0) ? m_cnt : exp;
        check("count", out_count, sat(want, 15));
        check("count_sat", out_count_s, sat(want, 1));
        check("sat_valid", out_valid_s, 1);
        held = out_count;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_count", out_count, int'(held));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("done_valid", out_valid, 0);
        check("done_ready", in_ready, 1);
        check("done_busy", busy, 0);
        check("idle_match", match, int'(m_match()));
    endtask

    typedef struct {
        logic [7:0] data;
        logic       chain;
        int         hold;
        int         exp_cnt;
        logic       exp_match;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'hAA, 1'b0, 0, 3, 1'b1};
        vecs[1] = '{8'h00, 1'b0, 5, 0, 1'b0};
        vecs[2] = '{8'h05, 1'b0, 0, 0, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 0, 1, 1'b0};
        vecs[4] = '{8'h05, 1'b0, 0, 0, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 0, 0, 1'b0};
        vecs[6] = '{8'h5A, 1'b0, 2, 1, 1'b1};
        vecs[7] = '{8'hAA, 1'b1, 0, 4, 1'b1};

        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_chain = 1'b0; out_ready = 1'b0;
        m_hist = '0; m_n = 0; m_cnt = 0;
        #12;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_match", match, 0);
        check("rst_count", out_count, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].data, vecs[i].chain, vecs[i].hold, 1'b0, vecs[i].exp_cnt);
            check("vec_match", match, int'(vecs[i].exp_match));
        end

        // Reset mid-SHIFT after three bits of 1010_1010 (detector at S3).
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hAA; in_chain = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", out_count, 0);
        m_n = 0;
        @(negedge clk);
        reset = 1'b1;
        send(8'h00, 1'b1, 0, 1'b0, 0);
        send(8'hAA, 1'b1, 0, 1'b0, 3);

        // Reset while REPORT is pending with match high: no out_valid may follow.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hAA; in_chain = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        check("rep_valid", out_valid, 1);
        check("rep_match", match, 1);
        #2;
        reset = 1'b0;
        #1;
        check("rep_rst_valid", out_valid, 0);
        check("rep_rst_match", match, 0);
        check("rep_rst_count", out_count, 0);
        m_n = 0;
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_valid", out_valid, 0);
        end
        out_ready = 1'b0;

        for (int i = 0; i < 40; i++) begin
            send(8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_match_ctrl.md
SEQ_MATCH_CTRL -- requirements
Module: seq_match_ctrl

Interface
REQ-001: Parameter WIDTH, default 8, is the bits per input word; legal range 2..32.
REQ-002: Parameter CNT_W, default 4, is the match-count width; legal range 1..8.
REQ-003: clk  input  1  the single clock; all state updates on its rising edge.
REQ-004: reset  input  1  asynchronous, active-low reset; reset=0 forces the reset state immediately, independent of clk.
REQ-005: in_valid  input  1  word offered on in_data.
REQ-006: in_ready  output  1  block can accept a word this cycle.
REQ-007: in_data  input  WIDTH  word to scan, serialized MSB first.
REQ-008: in_chain  input  1  sampled with the word: 1 = detector continues from prior state, 0 = detector restarts at S0.
REQ-009: out_valid  output  1  out_count is valid.
REQ-010: out_ready  input  1  consumer accepts out_count.
REQ-011: out_count  output  CNT_W  number of pattern matches found in the word.
REQ-012: match  output  1  high in any cycle where the detector state is S4.
REQ-013: busy  output  1  high whenever the controller is not in IDLE.

Function
REQ-014: The controller FSM has three states: IDLE, SHIFT and REPORT.
REQ-015: In IDLE, in_ray=1; in_valid=1 at a clock edge captures in_data and in_chain and moves to SHIFT.
REQ-016: At the capture edge, the detector goes to S0 if in_chain=0 and holds its state if in_chain=1; out_count clears to 0.
REQ-017: SHIFT lasts exactly WIDTH cycles; each edge presents one bit (MSB first, bit index WIDTH-1 down to 0) as input w to the detector.
REQ-018: Detector (Moore) transitions on each SHIFT edge, w=1/w=0: S0->S1/S0; S1->S1/S2; S2->S3/S0; S3->S1/S4; S4->S3/S0.
REQ-019: The detector reports the overlapping serial pattern 1010.
REQ-020: The detector state is unchanged outside SHIFT edges.
REQ-021: out_count increments on every SHIFT edge whose detector next state is S4.
REQ-022: out_count saturates at 2^CNT_W-1 and never wraps.
REQ-023: The edge that consumes bit 0 moves the FSM to REPORT, so out_valid rises exactly WIDTH edges after the capture edge.
REQ-024: In REPORT, out_valid=1 and out_count is held stable until out_valid&out_ready at an edge; that edge returns the FSM to IDLE.
REQ-025: in_ready=0 in SHIFT and REPORT, so there is no bypass; the minimum issue interval is WIDTH+2 cycles.
REQ-026: in_valid/in_data changes while not in IDLE are ignored; the captured word is not affected.
REQ-027: out_ready is ignored outside REPORT.
REQ-028: match = (detector state == S4) in every FSM state, including REPORT and IDLE after a chained word.
REQ-029: Unused detector encodings (5..7) recover to S0 on the next SHIFT edge.
REQ-030: Unused FSM encodings recover to IDLE on the next edge.

Reset
REQ-031: reset=0 forces the following, asynchronously: FSM=IDLE, detector=S0, out_count=0, out_valid=0, busy=0, match=0, in_ready=1.
REQ-032: Reset asserted during SHIFT or REPORT discards the word and its count; no out_valid follows.
REQ-033: After reset deasserts, the first accepted word behaves as in_chain=0 regardless of in_chain, because the detector is at S0.

Verification
REQ-034: WIDTH=8, CNT_W=4, in_data=8'b1010_1010, in_chain=0 -> out_valid 8 edges after capture; out_count=3; match high after shift edges 4, 6 and 8.
REQ-035: in_data=8'h00, in_chain=0 -> out_count=0, match never high.
REQ-036: Chaining: send 8'b0000_0101 (chain=0) -> out_count=0, detector ends in S3. Then send 8'h00 with chain=1 -> out_count=1. Repeating the pair with chain=0 on the second word -> out_count=0.
REQ-037: Backpressure: hold out_ready=0 for 5 cycles in REPORT -> out_valid=1, out_count stable, in_ready=0 throughout; IDLE is entered on the edge after out_ready=1.
REQ-038: Assert reset=0 mid-SHIFT (after 3 bits) -> all outputs at reset values immediately; then a new word 8'b1010_1010 -> out_count=3.
REQ-039: CNT_W=1, in_data=8'b1010_1010 -> out_count saturates at 1.
